// File: rtl/hex_to_seg_pkg.sv
// Shared constants for the hex-to-7-segment decoder.
//   SEG_W        : width of a segment vector (g,f,e,d,c,b,a; bit 0 = a)
//   GLYPH        : active-high glyph for each nibble 0x0..0xF
//   SEG_ALL_OFF  : active-high "nothing lit"
//   SEG_ALL_ON   : active-high "everything lit"
package hex_to_seg_pkg;

  localparam int unsigned SEG_W = 7;

  // Lowercase b and d keep them distinct from 8 and 0.
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_ALL_ON  = 7'h7F;

endpackage

// File: rtl/hex_seg_rom.sv
// Combinational glyph lookup.
//   x   : hex nibble
//   seg : active-high gfedcba pattern for x
module hex_seg_rom
  import hex_to_seg_pkg::*;
(
  input  logic [3:0]       x,
  output logic [SEG_W-1:0] seg
);

  // All 16 codes are covered, so no default branch is needed.
  always_comb begin
    seg = GLYPH[x];
  end

endmodule

// File: rtl/hex_to_seg.sv
// Registered hex-to-7-segment decoder for one digit.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   X         : hex nibble to display
//   blank     : 1 = all segments off
//   lamp_test : 1 = all segments on, overrides blank
//   SEG       : registered segment drive, SEG[6:0] = g,f,e,d,c,b,a
// Parameters:
//   ACTIVE_LOW  : 1 = a lit segment is driven 0 (common anode)
//   RESET_BLANK : 1 = reset to all-off, 0 = reset to the "0" glyph
module hex_to_seg
  import hex_to_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit RESET_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       X,
  input  logic             blank,
  input  logic             lamp_test,
  output logic [SEG_W-1:0] SEG
);

  // Reset value, expressed in active-high form then mapped to pin polarity.
  localparam logic [SEG_W-1:0] RST_HI  = RESET_BLANK ? SEG_ALL_OFF : GLYPH[0];
  localparam logic [SEG_W-1:0] RST_VAL = ACTIVE_LOW ? ~RST_HI : RST_HI;

  logic [SEG_W-1:0] glyph;
  logic [SEG_W-1:0] seg_hi;
  logic [SEG_W-1:0] seg_d;
  logic [SEG_W-1:0] seg_q;

  hex_seg_rom u_rom (
    .x   (X),
    .seg (glyph)
  );

  always_comb begin
    seg_hi = glyph;
    if (lamp_test) begin
      seg_hi = SEG_ALL_ON;
    end else if (blank) begin
      seg_hi = SEG_ALL_OFF;
    end
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= RST_VAL;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign SEG = seg_q;

endmodule

// File: tb/tb_hex_to_seg.sv
// Directed bench for hex_to_seg. Two instances share the stimulus:
//   dut_al : ACTIVE_LOW=1, RESET_BLANK=1
//   dut_ah : ACTIVE_LOW=0, RESET_BLANK=0
module tb_hex_to_seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] X;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_al;
  logic [6:0] seg_ah;

  int checks = 0;
  int errors = 0;

  // Hand-written expected tables indexed by nibble.
  logic [6:0] exp_lo [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [6:0] exp_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  hex_to_seg #(
    .ACTIVE_LOW  (1'b1),
    .RESET_BLANK (1'b1)
  ) dut_al (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .blank     (blank),
    .lamp_test (lamp_test),
    .SEG       (seg_al)
  );

  hex_to_seg #(
    .ACTIVE_LOW  (1'b0),
    .RESET_BLANK (1'b0)
  ) dut_ah (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .blank     (blank),
    .lamp_test (lamp_test),
    .SEG       (seg_ah)
  );

  // Advance one rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    X = 4'h5;
    blank = 1'b0;
    lamp_test = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (seg_al !== 7'h7F) begin
        errors++;
        $display("FAIL reset_al cyc %0d got %h want 7f", i, seg_al);
      end
      checks++;
      if (seg_ah !== 7'h3F) begin
        errors++;
        $display("FAIL reset_ah cyc %0d got %h want 3f", i, seg_ah);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (seg_al !== 7'h12) begin
      errors++;
      $display("FAIL reset_release_al got %h want 12", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h6D) begin
      errors++;
      $display("FAIL reset_release_ah got %h want 6d", seg_ah);
    end
  endtask

  task automatic test_sweep();
    for (int v = 15; v >= 0; v--) begin
      X = 4'(v);
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (seg_al !== exp_lo[v]) begin
          errors++;
          $display("FAIL sweep_al x=%h cyc %0d got %h want %h", v, c, seg_al, exp_lo[v]);
        end
        checks++;
        if (seg_ah !== exp_hi[v]) begin
          errors++;
          $display("FAIL sweep_ah x=%h cyc %0d got %h want %h", v, c, seg_ah, exp_hi[v]);
        end
      end
    end
  endtask

  task automatic test_latency();
    X = 4'h8;
    tick();
    checks++;
    if (seg_al !== 7'h00) begin
      errors++;
      $display("FAIL latency_8 got %h want 00", seg_al);
    end
    X = 4'h1;
    #1;
    // Input changed but no edge yet: output must still show 8.
    checks++;
    if (seg_al !== 7'h00) begin
      errors++;
      $display("FAIL latency_no_comb got %h want 00", seg_al);
    end
    tick();
    checks++;
    if (seg_al !== 7'h79) begin
      errors++;
      $display("FAIL latency_1 got %h want 79", seg_al);
    end
  endtask

  task automatic test_overrides();
    X = 4'h3;
    blank = 1'b1;
    tick();
    checks++;
    if (seg_al !== 7'h7F) begin
      errors++;
      $display("FAIL blank_al got %h want 7f", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h00) begin
      errors++;
      $display("FAIL blank_ah got %h want 00", seg_ah);
    end
    lamp_test = 1'b1;
    tick();
    checks++;
    if (seg_al !== 7'h00) begin
      errors++;
      $display("FAIL lamp_al got %h want 00", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h7F) begin
      errors++;
      $display("FAIL lamp_ah got %h want 7f", seg_ah);
    end
    blank = 1'b0;
    tick();
    checks++;
    if (seg_al !== 7'h00) begin
      errors++;
      $display("FAIL lamp_only_al got %h want 00", seg_al);
    end
    lamp_test = 1'b0;
    tick();
    checks++;
    if (seg_al !== 7'h30) begin
      errors++;
      $display("FAIL release_al got %h want 30", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h4F) begin
      errors++;
      $display("FAIL release_ah got %h want 4f", seg_ah);
    end
  endtask

  task automatic test_polarity();
    X = 4'hA;
    tick();
    checks++;
    if (seg_ah !== 7'h77) begin
      errors++;
      $display("FAIL polarity_ah got %h want 77", seg_ah);
    end
    checks++;
    if (seg_al !== 7'h08) begin
      errors++;
      $display("FAIL polarity_al got %h want 08", seg_al);
    end
  endtask

  task automatic test_reset_midstream();
    X = 4'h7;
    rst_n = 1'b0;
    tick();
    checks++;
    if (seg_al !== 7'h7F) begin
      errors++;
      $display("FAIL mid_reset_al got %h want 7f", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h3F) begin
      errors++;
      $display("FAIL mid_reset_ah got %h want 3f", seg_ah);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (seg_al !== 7'h78) begin
      errors++;
      $display("FAIL mid_release_al got %h want 78", seg_al);
    end
    checks++;
    if (seg_ah !== 7'h07) begin
      errors++;
      $display("FAIL mid_release_ah got %h want 07", seg_ah);
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 16; v++) begin
      X = 4'(v);
      tick();
      checks++;
      if (seg_al !== exp_lo[v]) begin
        errors++;
        $display("FAIL b2b_al x=%h got %h want %h", v, seg_al, exp_lo[v]);
      end
      checks++;
      if (seg_ah !== exp_hi[v]) begin
        errors++;
        $display("FAIL b2b_ah x=%h got %h want %h", v, seg_ah, exp_hi[v]);
      end
    end
    // Holding X must hold SEG.
    tick();
    checks++;
    if (seg_al !== exp_lo[15]) begin
      errors++;
      $display("FAIL hold_al got %h want %h", seg_al, exp_lo[15]);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency();
    test_overrides();
    test_polarity();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_to_seg.md
Name: hex_to_seg

Overview:
- Registered hexadecimal-to-7-segment decoder. It converts one 4-bit nibble (0x0–0xF) into the segment pattern for one 7-segment digit.
- Sits between the display-data logic and the board's segment pins, or in front of a digit-scan multiplexer.
- The output register is clocked, so segment pins are glitch-free.

Parameters:
- ACTIVE_LOW, 1, 1 = segment lit by driving 0 (common-anode board); 0 = lit by driving 1.
- RESET_BLANK, 1, 1 = SEG resets to all-off; 0 = SEG resets to the pattern for digit "0".

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- X  input  4  hex nibble to display.
- blank  input  1  1 = all segments off.
- lamp_test  input  1  1 = all segments on; overrides blank.
- SEG  output  7  segment drive, bit order SEG[6:0] = g,f,e,d,c,b,a (SEG[0] = a). Registered.

Behaviour:
- Reset:
  - When rst_n = 0 at a rising clk edge, SEG loads its reset value.
  - With RESET_BLANK = 1, the reset value is all-off: 7'h7F if ACTIVE_LOW, 7'h00 otherwise.
  - With RESET_BLANK = 0, the reset value is the "0" pattern.
  - Reset has priority over every other input.
- Latency:
  - SEG reflects the X, blank and lamp_test values sampled at edge N, and is valid after edge N.
  - This is one clock of latency. There is no combinational path from inputs to SEG.
- Priority, per cycle: rst_n low > lamp_test (all on) > blank (all off) > decode(X).
- Decode table, active-high gfedcba. The ACTIVE_LOW = 1 value is the bitwise inverse.
  - 0 → 3F
  - 1 → 06
  - 2 → 5B
  - 3 → 4F
  - 4 → 66
  - 5 → 6D
  - 6 → 7D
  - 7 → 07
  - 8 → 7F
  - 9 → 6F
  - A → 77
  - b → 7C
  - C → 39
  - d → 5E
  - E → 79
  - F → 71
- Active-low equivalents:
  - 0 → 40
  - 1 → 79
  - 2 → 24
  - 3 → 30
  - 4 → 19
  - 5 → 12
  - 6 → 02
  - 7 → 78
  - 8 → 00
  - 9 → 10
  - A → 08
  - b → 03
  - C → 46
  - d → 21
  - E → 06
  - F → 0E
- Lowercase glyphs are used for b and d so they are not confused with 8 and 0.
- The table is complete over all 16 codes; no default or X-propagation branch is reachable.
- X/Z on any input after reset: SEG is not required to be defined that cycle. It must recover on the next clean sample.
- Holding X constant holds SEG constant; there is no internal state beyond the output register.
- Back-to-back X changes every cycle are each reflected one cycle later, with no skipped values.
- Reset asserted mid-stream overrides the next edge. The first decode after rst_n rises appears one edge after release.

Decomposition:
- Package hex_to_seg_pkg holds:
  - SEG_W = 7
  - the 16-entry active-high glyph constant array
  - named constants SEG_ALL_OFF and SEG_ALL_ON (active-high form)
- One combinational sub-module, hex_seg_rom (4-bit in, 7-bit active-high out), implements the table.
- The top level applies the override priority, the polarity inversion and the output register.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with X = 4'h5 → SEG = 7'h7F (ACTIVE_LOW = 1, RESET_BLANK = 1) throughout. Release → SEG = 7'h12 one edge later.
- Full sweep: apply X = F,E,D…0, each held 20 ns (2 cycles at 100 MHz) → SEG = 0E,06,21,46,03,08,10,00,78,02,12,19,30,24,79,40 respectively, one cycle after each change.
- Latency: change X from 8 to 1 on consecutive cycles → SEG = 00 then 79, each exactly one edge after its input.
- Overrides: X = 4'h3, blank = 1 → 7'h7F. Add lamp_test = 1 → 7'h00 (lamp_test wins). Drop both → 7'h30.
- Polarity: ACTIVE_LOW = 0 build, X = 4'hA → 7'h77. Reset with RESET_BLANK = 0 → 7'h3F.
- Reset mid-stream: rst_n = 0 during a cycle where X changes to 4'h7 → SEG goes to reset value, not 78. After release, SEG = 78 one edge later.
